// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding and complex-word helpers for the radix-4 stage.
package fft_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int MAX_W = 32;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin end
    return r;
  endfunction
  // Component helpers work on words zero-extended to 2*MAX_W; components are sign-extended on unpack.
  function automatic logic signed [MAX_W-1:0] re_of(input logic [2*MAX_W-1:0] w, input int dw);
    logic signed [MAX_W-1:0] t;
    t = MAX_W'(w >> dw);
    return (t <<< (MAX_W - dw)) >>> (MAX_W - dw);
  endfunction
  function automatic logic signed [MAX_W-1:0] im_of(input logic [2*MAX_W-1:0] w, input int dw);
    logic signed [MAX_W-1:0] t;
    t = MAX_W'(w);
    return (t <<< (MAX_W - dw)) >>> (MAX_W - dw);
  endfunction
  function automatic logic [2*MAX_W-1:0] pack(input logic [MAX_W-1:0] re, input logic [MAX_W-1:0] im, input int dw);
    logic [2*MAX_W-1:0] mask;
    mask = ((2*MAX_W)'(1) << dw) - (2*MAX_W)'(1);
    return (((2*MAX_W)'(re) & mask) << dw) | ((2*MAX_W)'(im) & mask);
  endfunction
endpackage

// File: rtl/fft_r4_bfly.sv
// fft_r4_bfly: combinational radix-4 butterfly with trivial twiddles.
// FFT_R4_SAT_EN selects saturation with clip flag; otherwise floor divide-by-4.
module fft_r4_bfly
  import fft_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [2*DATA_W-1:0] a,
  input  logic [2*DATA_W-1:0] b,
  input  logic [2*DATA_W-1:0] c,
  input  logic [2*DATA_W-1:0] d,
  output logic [2*DATA_W-1:0] y0,
  output logic [2*DATA_W-1:0] y1,
  output logic [2*DATA_W-1:0] y2,
  output logic [2*DATA_W-1:0] y3,
  output logic                ovf
);
  localparam int W = DATA_W + 2;
  typedef logic signed [W-1:0] s_t;
  s_t ar, ai, br, bi, cr, ci, dr, di;
  s_t r [4];
  s_t i [4];
  logic [DATA_W-1:0] ro [4];
  logic [DATA_W-1:0] io [4];
  logic [2*DATA_W-1:0] yy [4];
  logic [7:0] clip;
  assign ar = W'(re_of((2*MAX_W)'(a), DATA_W));
  assign ai = W'(im_of((2*MAX_W)'(a), DATA_W));
  assign br = W'(re_of((2*MAX_W)'(b), DATA_W));
  assign bi = W'(im_of((2*MAX_W)'(b), DATA_W));
  assign cr = W'(re_of((2*MAX_W)'(c), DATA_W));
  assign ci = W'(im_of((2*MAX_W)'(c), DATA_W));
  assign dr = W'(re_of((2*MAX_W)'(d), DATA_W));
  assign di = W'(im_of((2*MAX_W)'(d), DATA_W));
  // -j*(x) = (xi, -xr) and +j*(x) = (-xi, xr)
  assign r[0] = ar + br + cr + dr;
  assign i[0] = ai + bi + ci + di;
  assign r[1] = ar + bi - cr - di;
  assign i[1] = ai - br - ci + dr;
  assign r[2] = ar - br + cr - dr;
  assign i[2] = ai - bi + ci - di;
  assign r[3] = ar - bi - cr + di;
  assign i[3] = ai + br - ci - dr;
`ifdef FFT_R4_SAT_EN
  localparam s_t MAXV = s_t'(2**(DATA_W-1) - 1);
  localparam s_t MINV = s_t'(-(2**(DATA_W-1)));
  for (genvar j = 0; j < 4; j++) begin : g_sat
    assign ro[j] = r[j] > MAXV ? MAXV[DATA_W-1:0] : r[j] < MINV ? MINV[DATA_W-1:0] : r[j][DATA_W-1:0];
    assign io[j] = i[j] > MAXV ? MAXV[DATA_W-1:0] : i[j] < MINV ? MINV[DATA_W-1:0] : i[j][DATA_W-1:0];
    assign clip[j]   = r[j] > MAXV || r[j] < MINV;
    assign clip[j+4] = i[j] > MAXV || i[j] < MINV;
  end
`else
  for (genvar j = 0; j < 4; j++) begin : g_scl
    assign ro[j] = DATA_W'(r[j] >>> 2);
    assign io[j] = DATA_W'(i[j] >>> 2);
  end
  assign clip = '0;
`endif
  for (genvar j = 0; j < 4; j++) begin : g_pk
    assign yy[j] = (2*DATA_W)'(pack(MAX_W'(ro[j]), MAX_W'(io[j]), DATA_W));
  end
  assign y0  = yy[0];
  assign y1  = yy[1];
  assign y2  = yy[2];
  assign y3  = yy[3];
  assign ovf = |clip;
endmodule

// File: rtl/fft_r4_stage_tdm.sv
// fft_r4_stage_tdm: time-multiplexed radix-4 DIF first stage, NUM_BF engines, frame in/out handshake.
// FFT_R4_SAT_EN in the butterflies turns scaling into saturation and drives the sticky ovf.
module fft_r4_stage_tdm
  import fft_pkg::*;
#(
  parameter int POINTS = 32,
  parameter int NUM_BF = 2,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [POINTS*2*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [POINTS*2*DATA_W-1:0]   out_data,
  output logic                         busy,
  output logic                         ovf
);
  localparam int Q      = POINTS / 4;
  localparam int CYCLES = Q / NUM_BF;
  localparam int CNT_W  = clog2(CYCLES) > 1 ? clog2(CYCLES) : 1;
  localparam int SW     = 2 * DATA_W;
  localparam int IW     = clog2(POINTS * SW);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [POINTS*SW-1:0] in_buf, out_buf;
  logic [IW-1:0] base [NUM_BF][4];
  logic [SW-1:0] y [NUM_BF][4];
  logic [NUM_BF-1:0] bov;
  logic ovf_q, accept;
  assign accept   = state == IDLE && in_valid;
  assign out_data = out_buf;
  assign ovf      = ovf_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
          state == RUN  ? (cnt == CNT_W'(CYCLES - 1) ? DONE : RUN) :
                          (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
  end
  // Engine e owns group k = cnt*NUM_BF + e and its four quarter-spaced samples.
  for (genvar e = 0; e < NUM_BF; e++) begin : g_bf
    for (genvar m = 0; m < 4; m++) begin : g_ix
      assign base[e][m] = IW'((int'(cnt) * NUM_BF + e + m * Q) * SW);
    end
    fft_r4_bfly #(.DATA_W(DATA_W)) u_bf (
      .a  (in_buf[base[e][0] +: SW]),
      .b  (in_buf[base[e][1] +: SW]),
      .c  (in_buf[base[e][2] +: SW]),
      .d  (in_buf[base[e][3] +: SW]),
      .y0 (y[e][0]),
      .y1 (y[e][1]),
      .y2 (y[e][2]),
      .y3 (y[e][3]),
      .ovf(bov[e])
    );
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt     <= '0;
      in_buf  <= '0;
      out_buf <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      in_buf  <= in_data;
      out_buf <= '0;
      ovf_q   <= 1'b0;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      ovf_q <= ovf_q | (|bov);
      for (int e = 0; e < NUM_BF; e++)
        for (int m = 0; m < 4; m++)
          out_buf[base[e][m] +: SW] <= y[e][m];
    end
endmodule

// File: tb/tb_fft_r4_stage_tdm.sv
// tb_fft_r4_stage_tdm: frame-level reference model with directed and random frames.
// Build with FFT_R4_SAT_EN to check the saturating variant.
module tb_fft_r4_stage_tdm;
  localparam int P  = 32;
  localparam int Q  = P / 4;
  localparam int SW = 32;
`ifdef FFT_R4_SAT_EN
  localparam int DIV = 1;
  localparam bit SAT = 1'b1;
`else
  localparam int DIV = 4;
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [P*SW-1:0] in_data = '0, exp_data = '0;
  logic [P*SW-1:0] out_data;
  logic in_ready, out_valid, busy, ovf;
  logic exp_ovf = 1'b0;
  int checks = 0, passed = 0;
  int xr [P], xi [P], er [P], ei [P];

  always #5 clk = ~clk;

  fft_r4_stage_tdm #(.POINTS(P), .NUM_BF(2), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int fix(input int v);
    if (SAT) begin
      if (v > 32767) begin exp_ovf = 1'b1; return 32767; end
      if (v < -32768) begin exp_ovf = 1'b1; return -32768; end
      return v;
    end
    return (v - (((v % 4) + 4) % 4)) / 4;
  endfunction

  // Reference: X_m[k] = sum_n x[k+nQ] * (-j)^(m*n), then scale or clamp.
  task automatic model();
    int sr, si, wr, wi, t;
    exp_ovf = 1'b0;
    for (int k = 0; k < Q; k++)
      for (int m = 0; m < 4; m++) begin
        sr = 0; si = 0;
        for (int n = 0; n < 4; n++) begin
          wr = xr[k+n*Q]; wi = xi[k+n*Q];
          for (int r = 0; r < (m * n) % 4; r++) begin t = wr; wr = wi; wi = -t; end
          sr += wr; si += wi;
        end
        er[k+m*Q] = fix(sr);
        ei[k+m*Q] = fix(si);
      end
    for (int i = 0; i < P; i++) begin
      exp_data[i*SW +: SW] = {16'(er[i]), 16'(ei[i])};
      in_data[i*SW +: SW]  = {16'(xr[i]), 16'(xi[i])};
    end
  endtask

  function automatic int re_at(input int i);
    return int'($signed(out_data[i*SW+16 +: 16]));
  endfunction
  function automatic int im_at(input int i);
    return int'($signed(out_data[i*SW +: 16]));
  endfunction

  task automatic clear_x();
    for (int i = 0; i < P; i++) begin xr[i] = 0; xi[i] = 0; end
  endtask

  task automatic offer();
    model();
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("busy_run", busy, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 4);
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  always @(negedge clk)
    if (reset && out_valid) begin
      checks++;
      if (out_data === exp_data) passed++;
      else
        for (int i = 0; i < P; i++)
          if (out_data[i*SW +: SW] !== exp_data[i*SW +: SW]) begin
            $display("FAIL frame: sample %0d got %h, expected %h", i, out_data[i*SW +: SW], exp_data[i*SW +: SW]);
            break;
          end
      chk("ovf_done", ovf, exp_ovf);
    end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_data", out_data == '0, 1);

    clear_x(); xr[0] = 400;
    offer(); wait_done();
    for (int m = 0; m < 4; m++) begin
      chk("imp_re", re_at(m*Q), 400 / DIV);
      chk("imp_im", im_at(m*Q), 0);
    end
    chk("imp_zero", re_at(1), 0);
    release_out(1);

    clear_x(); xi[8] = 400;
    offer(); wait_done();
    chk("j_y0_im", im_at(0), 400 / DIV);
    chk("j_y1_re", re_at(8), 400 / DIV);
    chk("j_y2_im", im_at(16), -400 / DIV);
    chk("j_y3_re", re_at(24), -400 / DIV);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      if (i == 4) begin in_valid = 1'b1; in_data = {P{32'h1234_5678}}; end
      if (i == 5) in_valid = 1'b0;
    end
    release_out(0);
    @(negedge clk);
    chk("bp_not_taken", busy, 0);
    chk("bp_hold_data", out_data == exp_data, 1);

    clear_x(); xr[3] = 1000; xi[20] = -777;
    offer();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data == '0, 1);
    @(negedge clk) reset = 1'b1;
    offer(); wait_done(); release_out(0);

    clear_x(); for (int m = 0; m < 4; m++) xr[m*Q] = 32767;
    offer(); wait_done();
    chk("big_y0", re_at(0), 32767);
    chk("big_y1", re_at(8), 0);
    chk("big_ovf", ovf, SAT);
    release_out(2);
    @(negedge clk) chk("ovf_sticky", ovf, SAT);

    clear_x(); xr[0] = -3;
    offer();
    chk("ovf_cleared", ovf, 0);
    wait_done();
    for (int m = 0; m < 4; m++) chk("round", re_at(m*Q), SAT ? -3 : -1);
    release_out(0);

    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < P; i++) begin
        xr[i] = int'($signed(16'($urandom)));
        xi[i] = int'($signed(16'($urandom)));
      end
      if (f % 5 == 0) for (int i = 0; i < P; i++) begin xr[i] = (i % 2) ? -32768 : 32767; xi[i] = -32768; end
      offer(); wait_done(); release_out($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fft_r4_stage_tdm.md
Name: fft_r4_stage_tdm

Overview:
Parametrised, time-multiplexed radix-4 DIF first stage using only the trivial twiddles {1, -j, -1, +j}.
- Accepts a full frame of POINTS complex fixed-point samples on a flat bus.
- Computes all POINTS/4 butterflies using NUM_BF parallel engines over several cycles.
- Returns the frame in place through a valid/ready handshake.
- Successor to the fixed 32-point float MAC stage: generic size, engine count and width, registered outputs, flow control and overflow handling.

Parameters:
- POINTS, 32, frame size. Power of 2, ≥4. Q = POINTS/4.
- NUM_BF, 2, parallel butterfly engines. Power of 2 that divides Q.
- DATA_W, 16, two's-complement width of each real/imag component.
- Derived: CYCLES = Q/NUM_BF, with CNT_W = max(1, clog2(CYCLES)).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  frame offered
- in_ready  out  1  block can accept a frame
- in_data  in  POINTS*2*DATA_W  sample i at [i*2*DATA_W +: 2*DATA_W], {re, im} with re in the upper half
- out_valid  out  1  result frame held
- out_ready  in  1  consumer accepts the result
- out_data  out  POINTS*2*DATA_W  same packing as in_data
- busy  out  1  high in RUN or DONE
- ovf  out  1  sticky saturation flag (only meaningful with the optional feature)

Behaviour:
- Reset values: state=IDLE, cnt=0, input and output buffers=0, out_valid=0, ovf=0. in_ready=1 once reset is released. Reset asserted mid-frame aborts the frame immediately, with no partial output.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into the input buffer, clear the output buffer, set cnt=0, clear ovf, go to RUN.
- RUN:
  - in_ready=0.
  - Engine e processes group k = cnt*NUM_BF + e with a=x[k], b=x[k+Q], c=x[k+2Q], d=x[k+3Q].
  - y0=a+b+c+d; y1=a-jb-c+jd; y2=a-b+c-d; y3=a+jb-c-jd.
  - Results are registered into out buffer indices k, k+Q, k+2Q, k+3Q.
  - cnt increments every cycle. When cnt==CYCLES-1, go to DONE.
- DONE:
  - out_valid=1 and out_data holds stable.
  - in_valid is ignored in this state.
  - On out_ready, go to IDLE on the next edge. out_valid drops; out_data keeps its value until the next accept.
- Latency: if the frame is accepted at edge E0, out_valid is high after edge E_CYCLES, i.e. CYCLES cycles later. Throughput is one frame per CYCLES+2 cycles minimum.
- Arithmetic: sums are computed at DATA_W+2 bits, so no internal overflow.
- Default output: arithmetic shift right by 2 (floor), truncated to DATA_W. This can never overflow.
- Multiplying by ±j swaps re/im and negates one component. Negating the most negative value is exact because of the DATA_W+2 intermediates.

Optional Feature:
- FFT_R4_SAT_EN defined: no scaling. Each DATA_W+2 result saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clipped component sets ovf, which is sticky until the next frame is accepted.
- Undefined: divide-by-4 scaling as described above; ovf is tied to 0.

Decomposition:
- Package fft_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - the clog2 function;
  - complex pack/unpack helper functions (re/im slice of a 2*DATA_W word).
- Sub-module fft_r4_bfly: combinational single radix-4 engine, parametrised by DATA_W, with the scale/saturate logic and a per-engine ovf output. It is instantiated NUM_BF times in a generate loop.

Test Plan (POINTS=32, NUM_BF=2, DATA_W=16, CYCLES=4):
- Impulse, x[0]=(400,0), all others 0 → out[0], out[8], out[16], out[24] = (100,0), all else 0. out_valid exactly 4 cycles after accept.
- x[8]=(0,400), all others 0 → out[0]=(0,100), out[8]=(100,0), out[16]=(0,-100), out[24]=(-100,0).
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE and pulse in_valid → out_data stable, in_ready=0, the second frame is not taken.
  - Then out_ready=1 → in_ready=1 next cycle.
- Reset asserted in the second RUN cycle → out_valid=0, busy=0, out_data=0 asynchronously. A new frame after release completes normally.
- x[0]=x[8]=x[16]=x[24]=(32767,0):
  - default → out[0]=(32767,0), others 0, ovf=0;
  - with FFT_R4_SAT_EN → out[0]=(32767,0) saturated, ovf=1 until the next accept.
- Rounding, x[0]=(-3,0) only → default gives all four outputs (-1,0), the floor of -3/4. With FFT_R4_SAT_EN all four are (-3,0).
